// File: rtl/i2c_bus_recovery.sv
// I2C stuck-bus detector and recovery sequencer: watches the synchronised bus,
// and after a stuck timeout clocks SCL up to 9 times, issues a STOP and checks the result.
module i2c_bus_recovery #(
  parameter int unsigned CLK_PER_US  = 24,
  parameter int unsigned STUCK_MS    = 25,
  parameter int unsigned SCL_HALF_US = 5
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic enable,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_oe,
  output logic sda_oe,
  output logic recovering,
  output logic stuck_detect,
  output logic recover_done,
  output logic recover_fail
);
  localparam int unsigned PRE_W  = 8;
  localparam int unsigned HALF_W = 8;
  localparam int unsigned US_W   = 10;
  localparam int unsigned MS_W   = 8;
  localparam int unsigned PC_W   = 4;

  typedef enum logic [2:0] {
    IDLE, MONITOR, REC_LOW, REC_HIGH, STOP_A, STOP_B, STOP_C, CHECK
  } state_e;

  state_e            state_q, state_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [US_W-1:0]   us_q, us_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic [PC_W-1:0]   pulse_q, pulse_d;
  logic              scl_meta_q, scl_s_q, scl_prev_q, sda_meta_q, sda_s_q;
  logic              scl_oe_q, sda_oe_q, rec_q, stuck_q, done_q, fail_q;
  logic              scl_oe_d, sda_oe_d, rec_d, stuck_d, done_d, fail_d;
  logic              us_tick_c, half_end_c, scl_edge_c, stuck_c, timeout_c, timed_c;

  // Two-flop synchronisers; idle bus level is high
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_meta_q <= 1'b1;
      scl_s_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_s_q    <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_s_q    <= scl_meta_q;
      scl_prev_q <= scl_s_q;
      sda_meta_q <= sda_in;
      sda_s_q    <= sda_meta_q;
    end
  end

  assign us_tick_c  = (presc_q == PRE_W'(CLK_PER_US - 1));
  assign half_end_c = us_tick_c && (half_q == HALF_W'(SCL_HALF_US - 1));
  assign scl_edge_c = scl_s_q ^ scl_prev_q;
  assign stuck_c    = !scl_s_q || !sda_s_q;
  assign timeout_c  = (ms_q == MS_W'(STUCK_MS));
  assign timed_c    = (state_q == REC_LOW) || (state_q == REC_HIGH) || (state_q == STOP_A) ||
                      (state_q == STOP_B) || (state_q == STOP_C);

  always_comb begin
    state_d  = state_q;
    presc_d  = us_tick_c ? '0 : presc_q + PRE_W'(1);
    half_d   = '0;
    us_d     = '0;
    ms_d     = '0;
    pulse_d  = pulse_q;
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    rec_d    = 1'b0;
    stuck_d  = 1'b0;
    done_d   = 1'b0;
    fail_d   = 1'b0;

    case (state_q)
      IDLE:    state_d = MONITOR;
      MONITOR: begin
        if (timeout_c) begin
          state_d = REC_LOW;
          stuck_d = 1'b1;
        end else if (stuck_c && !scl_edge_c) begin
          us_d = us_q;
          ms_d = ms_q;
          if (us_tick_c) begin
            if (us_q == US_W'(999)) begin
              us_d = '0;
              ms_d = ms_q + MS_W'(1);
            end else begin
              us_d = us_q + US_W'(1);
            end
          end
        end
      end
      REC_LOW: begin
        scl_oe_d = 1'b1;
        rec_d    = 1'b1;
        if (half_end_c) state_d = REC_HIGH;
      end
      REC_HIGH: begin
        rec_d = 1'b1;
        if (half_end_c) begin
          pulse_d = pulse_q + PC_W'(1);
          state_d = (sda_s_q || pulse_q == PC_W'(8)) ? STOP_A : REC_LOW;
        end
      end
      STOP_A: begin
        scl_oe_d = 1'b1;
        sda_oe_d = 1'b1;
        rec_d    = 1'b1;
        if (half_end_c) state_d = STOP_B;
      end
      STOP_B: begin
        sda_oe_d = 1'b1;
        rec_d    = 1'b1;
        if (half_end_c) state_d = STOP_C;
      end
      STOP_C: begin
        rec_d = 1'b1;
        if (half_end_c) state_d = CHECK;
      end
      CHECK: begin
        rec_d   = 1'b1;
        done_d  = scl_s_q && sda_s_q;
        fail_d  = !(scl_s_q && sda_s_q);
        pulse_d = '0;
        state_d = MONITOR;
      end
      default: state_d = IDLE;
    endcase

    // Recovery phases are timed purely by us_ticks; SCL stretching is ignored
    if (timed_c && us_tick_c) half_d = half_q + HALF_W'(1);
    else if (timed_c)         half_d = half_q;

    if (state_d != state_q) begin
      presc_d = '0;
      half_d  = '0;
    end

    // Disable overrides everything, including a same-cycle timeout
    if (!enable) begin
      state_d  = IDLE;
      presc_d  = '0;
      half_d   = '0;
      us_d     = '0;
      ms_d     = '0;
      pulse_d  = '0;
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      rec_d    = 1'b0;
      stuck_d  = 1'b0;
      done_d   = 1'b0;
      fail_d   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      half_q   <= '0;
      us_q     <= '0;
      ms_q     <= '0;
      pulse_q  <= '0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      rec_q    <= 1'b0;
      stuck_q  <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      half_q   <= half_d;
      us_q     <= us_d;
      ms_q     <= ms_d;
      pulse_q  <= pulse_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      rec_q    <= rec_d;
      stuck_q  <= stuck_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
    end
  end

  assign scl_oe       = scl_oe_q;
  assign sda_oe       = sda_oe_q;
  assign recovering   = rec_q;
  assign stuck_detect = stuck_q;
  assign recover_done = done_q;
  assign recover_fail = fail_q;
endmodule

// File: tb/tb_i2c_bus_recovery.sv
// Bench for i2c_bus_recovery: open-drain bus model, queued expected events
// checked by an independent monitor.
module tb_i2c_bus_recovery;
  localparam int unsigned CLK_PER_US  = 4;
  localparam int unsigned STUCK_MS    = 2;
  localparam int unsigned SCL_HALF_US = 2;
  localparam longint HALF_CLK  = longint'(SCL_HALF_US * CLK_PER_US);
  localparam longint STUCK_CLK = longint'(STUCK_MS * 1000 * CLK_PER_US);

  logic sys_clk = 1'b0;
  logic sys_rst_n, enable, scl_ext, sda_ext;
  logic scl_in, sda_in, scl_oe, sda_oe, recovering, stuck_detect, recover_done, recover_fail;

  assign scl_in = scl_ext & ~scl_oe;
  assign sda_in = sda_ext & ~sda_oe;

  i2c_bus_recovery #(.CLK_PER_US(CLK_PER_US), .STUCK_MS(STUCK_MS), .SCL_HALF_US(SCL_HALF_US)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .recovering(recovering), .stuck_detect(stuck_detect),
    .recover_done(recover_done), .recover_fail(recover_fail)
  );

  always #5 sys_clk = ~sys_clk;

  typedef enum int {EV_STUCK, EV_DONE, EV_FAIL} ev_e;
  typedef struct {
    ev_e    kind;
    longint t_lo;
    longint t_hi;
    int     pulses;
  } exp_t;

  exp_t   exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  int     stuck_seen = 0, done_seen = 0, fail_seen = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_ev(input ev_e kind, input longint lo, input longint hi, input int pulses);
    exp_t e;
    e.kind = kind; e.t_lo = lo; e.t_hi = hi; e.pulses = pulses;
    exp_q.push_back(e);
  endtask

  // Reference outcome: released during the k-th high phase -> k pulses and done; never -> 9 and fail
  task automatic expect_recovery(input longint t0, input int k, input bit released);
    push_ev(EV_STUCK, t0 + STUCK_CLK, t0 + STUCK_CLK + longint'(CLK_PER_US) + 4, 0);
    push_ev(released ? EV_DONE : EV_FAIL, 0, 0, released ? k : 9);
  endtask

  // Monitor: pops the scoreboard on each pulse and checks phase lengths
  int  rec_pulses = 0, scl_run = 0, sda_run = 0;
  logic p_stuck = 1'b0, p_done = 1'b0, p_fail = 1'b0, p_scl = 1'b0;

  task automatic pop_check(input ev_e kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cyc %0d expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", longint'(kind), longint'(e.kind));
      if (kind == EV_STUCK) check_rng("stuck_time", cyc, e.t_lo, e.t_hi);
      else                  check("scl_pulse_count", rec_pulses, e.pulses);
    end
  endtask

  always @(negedge sys_clk) begin
    if (p_stuck) check("stuck_width", stuck_detect, 0);
    if (p_done)  check("done_width", recover_done, 0);
    if (p_fail)  check("fail_width", recover_fail, 0);
    if (stuck_detect && !p_stuck) begin stuck_seen++; rec_pulses = 0; pop_check(EV_STUCK); end
    if (recover_done && !p_done)  begin done_seen++;  pop_check(EV_DONE);  end
    if (recover_fail && !p_fail)  begin fail_seen++;  pop_check(EV_FAIL);  end
    if (scl_oe && !p_scl && !sda_oe) rec_pulses++;
    if (scl_oe) scl_run++;
    else begin
      if (p_scl && recovering) check("scl_low_phase_len", scl_run, HALF_CLK);
      scl_run = 0;
    end
    if (sda_oe) sda_run++;
    else begin
      if (sda_run != 0 && recovering) check("sda_low_phase_len", sda_run, 2 * HALF_CLK);
      sda_run = 0;
    end
    p_stuck = stuck_detect; p_done = recover_done; p_fail = recover_fail; p_scl = scl_oe;
  end

  task automatic wait_q(input int target, input longint budget, input string name);
    longint dl = cyc + budget;
    while (exp_q.size() > target && cyc < dl) @(negedge sys_clk);
    n_tests++;
    if (exp_q.size() > target) begin
      n_fail++;
      $display("FAIL %s_timeout: pending %0d expected %0d", name, exp_q.size(), target);
      exp_q.delete();
    end
  endtask

  // Wait for the k-th REC_LOW -> REC_HIGH transition (SCL released, SDA not driven)
  task automatic wait_rec_high(input int k);
    int     seen = 0;
    logic   ps = scl_oe;
    longint dl = cyc + 4000;
    while (seen < k && cyc < dl) begin
      @(negedge sys_clk);
      if (!scl_oe && ps && !sda_oe && recovering) seen++;
      ps = scl_oe;
    end
    if (seen < k) check("rec_high_timeout", seen, k);
  endtask

  task automatic sda_round(input int k);
    longint t0;
    repeat ($urandom_range(1, 20)) @(negedge sys_clk);
    t0 = cyc;
    sda_ext = 1'b0;
    expect_recovery(t0, k, k <= 9);
    wait_q(1, STUCK_CLK + 2000, "stuck");
    if (k <= 9) begin
      wait_rec_high(k);
      sda_ext = 1'b1;
    end
    wait_q(0, 4000, "recovery");
    sda_ext = 1'b1;
    repeat (20) @(negedge sys_clk);
  endtask

  initial begin
    #1_500_000;
    n_fail++;
    $display("FAIL watchdog: simulation time exceeded");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    longint t0;
    int d0, f0, s0;
    sys_rst_n = 1'b0; enable = 1'b0; scl_ext = 1'b1; sda_ext = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_recovering", recovering, 0);
    check("rst_stuck", stuck_detect, 0);
    check("rst_done", recover_done, 0);
    check("rst_fail", recover_fail, 0);
    sys_rst_n = 1'b1;
    sda_ext = 1'b0;
    repeat (10) @(negedge sys_clk);
    check("idle_no_enable_stuck", stuck_seen, 0);
    check("idle_no_enable_scl_oe", scl_oe, 0);
    sda_ext = 1'b1;
    enable = 1'b1;
    repeat (10) @(negedge sys_clk);

    // SCL held low externally: one pulse, SDA seen high, STOP, SCL still low -> fail
    t0 = cyc;
    scl_ext = 1'b0;
    push_ev(EV_STUCK, t0 + STUCK_CLK, t0 + STUCK_CLK + longint'(CLK_PER_US) + 4, 0);
    push_ev(EV_FAIL, 0, 0, 1);
    wait_q(0, STUCK_CLK + 4000, "scl_stuck");
    scl_ext = 1'b1;
    repeat (20) @(negedge sys_clk);

    // SDA stuck: released in the 3rd high phase, never released, then a random phase
    sda_round(3);
    sda_round(10);
    sda_round($urandom_range(1, 9));

    // SCL toggling with SDA low never times out
    s0 = stuck_seen;
    sda_ext = 1'b0;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1600, 2400)) @(negedge sys_clk);
      scl_ext = ~scl_ext;
    end
    sda_ext = 1'b1;
    repeat (20) @(negedge sys_clk);
    check("toggle_no_stuck", stuck_seen - s0, 0);

    // Enable dropped during REC_LOW
    t0 = cyc;
    sda_ext = 1'b0;
    push_ev(EV_STUCK, t0 + STUCK_CLK, t0 + STUCK_CLK + longint'(CLK_PER_US) + 4, 0);
    wait_q(0, STUCK_CLK + 2000, "stuck_en");
    repeat ($urandom_range(1, 5)) @(negedge sys_clk);
    check("in_rec_low_scl_oe", scl_oe, 1);
    d0 = done_seen; f0 = fail_seen;
    enable = 1'b0;
    @(negedge sys_clk);
    check("disable_scl_oe", scl_oe, 0);
    check("disable_recovering", recovering, 0);
    check("disable_sda_oe", sda_oe, 0);
    repeat (40) @(negedge sys_clk);
    check("disable_no_done", done_seen - d0, 0);
    check("disable_no_fail", fail_seen - f0, 0);
    sda_ext = 1'b1;
    enable = 1'b1;
    repeat (10) @(negedge sys_clk);

    // Asynchronous reset in the middle of STOP_B
    t0 = cyc;
    sda_ext = 1'b0;
    push_ev(EV_STUCK, t0 + STUCK_CLK, t0 + STUCK_CLK + longint'(CLK_PER_US) + 4, 0);
    wait_q(0, STUCK_CLK + 2000, "stuck_rst");
    t0 = cyc + 1000;
    while (!(sda_oe && !scl_oe) && cyc < t0) @(negedge sys_clk);
    check("reached_stop_b", sda_oe && !scl_oe, 1);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("async_rst_sda_oe", sda_oe, 0);
    check("async_rst_scl_oe", scl_oe, 0);
    check("async_rst_recovering", recovering, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    sda_ext = 1'b1;
    repeat (10) @(negedge sys_clk);
    check("post_rst_idle_rec", recovering, 0);
    d0 = done_seen; f0 = fail_seen;
    enable = 1'b1;
    repeat (30) @(negedge sys_clk);
    check("post_rst_no_done", done_seen - d0, 0);
    check("post_rst_no_fail", fail_seen - f0, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_bus_recovery.md
I2C_BUS_RECOVERY -- requirements
Module: i2c_bus_recovery

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 24, meaning sys_clk cycles per 1 us tick (legal 2..255).
REQ-002 SHALL have parameter STUCK_MS, default 25, meaning stuck-bus threshold in ms (legal 1..255).
REQ-003 SHALL have parameter SCL_HALF_US, default 5, meaning recovery SCL half-period in us (legal 1..255).
REQ-004 SHALL have port sys_clk, input, width 1, the clock; all logic is on its rising edge.
REQ-005 SHALL have port sys_rst_n, input, width 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port enable, input, width 1, which enables monitoring and recovery.
REQ-007 SHALL have ports scl_in and sda_in, input, width 1 each, the raw bus levels (asynchronous).
REQ-008 SHALL have ports scl_oe and sda_oe, output, width 1 each; 1 = pull line low, 0 = release.
REQ-009 SHALL have port recovering, output, width 1, high while in any recovery state.
REQ-010 SHALL have ports stuck_detect, recover_done and recover_fail, output, width 1 each; each is a one-cycle pulse.

Function
REQ-011 SHALL synchronise scl_in and sda_in through 2 flops each; all decisions use the synchronised values scl_s and sda_s.
REQ-012 SHALL run the us prescaler 0..CLK_PER_US-1 while enable=1; us_tick is asserted when count=CLK_PER_US-1, after which the count wraps to 0.
REQ-013 SHALL clear the us-within-ms counter (10b, 0..999) and the ms counter (8b) whenever the stuck condition is false or an scl_s edge occurs.
REQ-014 SHALL define the stuck condition, in MONITOR only, as: scl_s=0, or (scl_s=1 and sda_s=0).
REQ-015 SHALL advance the us-within-ms counter on each us_tick; at 999 it wraps to 0 and increments the ms counter.
REQ-016 SHALL, when the ms counter reaches STUCK_MS, pulse stuck_detect and enter REC_LOW in the next cycle.
REQ-017 SHALL implement states IDLE, MONITOR, REC_LOW, REC_HIGH, STOP_A, STOP_B, STOP_C, CHECK.
REQ-018 SHALL hold the FSM in IDLE while enable=0; enable=1 moves it to MONITOR.
REQ-019 SHALL use a half-period counter in all recovery states; each state lasts SCL_HALF_US us_ticks, counted from state entry with the prescaler cleared on entry.
REQ-020 SHALL, in REC_LOW, set scl_oe=1 and sda_oe=0; at the end of the half period it goes to REC_HIGH.
REQ-021 SHALL, in REC_HIGH, set scl_oe=0 and sda_oe=0; at the end of the half period it increments pulse_cnt (4b).
REQ-022 SHALL, at the end of REC_HIGH, go to STOP_A if sda_s=1 or pulse_cnt=9; otherwise it returns to REC_LOW.
REQ-023 SHALL drive the STOP sequence as follows: STOP_A scl_oe=1, sda_oe=1; STOP_B scl_oe=0, sda_oe=1; STOP_C scl_oe=0, sda_oe=0; each for one half period.
REQ-024 SHALL, in CHECK (one cycle), pulse recover_done if scl_s=1 and sda_s=1, else pulse recover_fail; it then goes to MONITOR with all counters and pulse_cnt cleared.
REQ-025 SHALL assert recovering in REC_LOW, REC_HIGH, STOP_A, STOP_B, STOP_C and CHECK.
REQ-026 SHALL ignore scl_in clock stretching during recovery; phases are strictly timed.
REQ-027 SHALL, when enable falls in any state, go to IDLE next cycle: outputs 0, counters 0, no done/fail pulse.
REQ-028 SHALL register all outputs, which therefore change one cycle after the state transition.
REQ-029 SHALL give enable and stuck-timeout expiry in the same cycle to enable; enable wins.

Reset
REQ-030 SHALL, on sys_rst_n=0, immediately force the FSM to IDLE, scl_oe=0, sda_oe=0, recovering=0 and all pulses 0.
REQ-031 SHALL, on sys_rst_n=0, clear all counters and pulse_cnt, and set the synchroniser flops to 1 (bus idle).
REQ-032 SHALL, on reset release, wait for enable=1 before leaving IDLE.

Verification
REQ-033 SHALL be verified with CLK_PER_US=4, STUCK_MS=2, SCL_HALF_US=2 against each scenario below.
REQ-034 SHALL pass this scenario: enable=1, scl_in held 0 -> stuck_detect pulses 2000 us_ticks (8000 clk, +2 sync) after the hold, then scl_oe toggles at 8-clk half periods.
REQ-035 SHALL pass this scenario: SDA stuck low; sda_in released after the 3rd REC_HIGH -> exactly 3 SCL pulses, then STOP_A..C, recover_done=1 for one cycle.
REQ-036 SHALL pass this scenario: sda_in never released -> 9 SCL pulses, STOP sequence, recover_fail=1 for one cycle, FSM returns to MONITOR.
REQ-037 SHALL pass this scenario: scl_in toggles every 500 us with SDA low -> no stuck_detect ever.
REQ-038 SHALL pass this scenario: enable dropped during REC_LOW -> scl_oe=0 and recovering=0 the next cycle, no done/fail pulse.
REQ-039 SHALL pass this scenario: sys_rst_n asserted mid-STOP_B -> sda_oe=0 immediately (asynchronous), FSM restarts in IDLE.
